// File: rtl/iq_entry_allocator.sv
// Issue-queue free-entry manager: tracks busy entries, offers the two lowest free
// entries to dispatch, raises the dispatch stall and reclaims entries on issue/kill.
module iq_entry_allocator #(
    parameter int IQ_ENT_NUM = 16,
    parameter int IQ_ENT_SEL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  invalid1,
    input  logic                  invalid2,
    input  logic                  ext_stall,
    output logic [IQ_ENT_SEL-1:0] iq_entry_num_1,
    output logic [IQ_ENT_SEL-1:0] iq_entry_num_2,
    output logic                  stall_DP,
    input  logic                  free_1,
    input  logic [IQ_ENT_SEL-1:0] free_entry_1,
    input  logic                  free_2,
    input  logic [IQ_ENT_SEL-1:0] free_entry_2,
    input  logic                  prmiss,
    input  logic [IQ_ENT_NUM-1:0] kill_mask,
    output logic [IQ_ENT_SEL:0]   free_cnt,
    output logic                  allocatable
);

    logic [IQ_ENT_NUM-1:0] busy_q, busy_d;
    logic [IQ_ENT_SEL:0]   free_cnt_q, free_cnt_d;
    logic                  allocatable_q, allocatable_d;
    logic [IQ_ENT_NUM-1:0] alloc_set_s, free_clr_s, kill_clr_s;
    logic                  found1_s, found2_s, short_s;

    function automatic logic [IQ_ENT_SEL:0] count_free(input logic [IQ_ENT_NUM-1:0] busy);
        logic [IQ_ENT_SEL:0] cnt;
        cnt = '0;
        for (int i = 0; i < IQ_ENT_NUM; i++) begin
            cnt = cnt + {{IQ_ENT_SEL{1'b0}}, ~busy[i]};
        end
        return cnt;
    endfunction

    // Priority search for the two lowest-numbered free entries in the registered bitmap.
    always_comb begin
        iq_entry_num_1 = '0;
        iq_entry_num_2 = '0;
        found1_s       = 1'b0;
        found2_s       = 1'b0;
        for (int i = 0; i < IQ_ENT_NUM; i++) begin
            if (!busy_q[i] && !found1_s) begin
                iq_entry_num_1 = IQ_ENT_SEL'(i);
                found1_s       = 1'b1;
            end else if (!busy_q[i] && !found2_s) begin
                iq_entry_num_2 = IQ_ENT_SEL'(i);
                found2_s       = 1'b1;
            end else begin
                found2_s = found2_s;
            end
        end
    end

    // Dispatch stall and all-or-nothing allocation.
    always_comb begin
        short_s  = (~invalid1 & (free_cnt_q == {(IQ_ENT_SEL+1){1'b0}})) |
                   (~invalid2 & (free_cnt_q < (IQ_ENT_SEL+1)'(2)));
        stall_DP = ext_stall | short_s | prmiss;
        alloc_set_s = '0;
        if (!stall_DP) begin
            alloc_set_s[iq_entry_num_1] = ~invalid1;
            alloc_set_s[iq_entry_num_2] = alloc_set_s[iq_entry_num_2] | ~invalid2;
        end else begin
            alloc_set_s = '0;
        end
    end

    // Releases only clear entries that are actually busy, so stale frees are no-ops.
    always_comb begin
        free_clr_s = '0;
        if (free_1) begin
            free_clr_s[free_entry_1] = 1'b1;
        end else begin
            free_clr_s = free_clr_s;
        end
        if (free_2) begin
            free_clr_s[free_entry_2] = 1'b1;
        end else begin
            free_clr_s = free_clr_s;
        end
        free_clr_s = free_clr_s & busy_q;
        if (prmiss) begin
            kill_clr_s = kill_mask & busy_q;
        end else begin
            kill_clr_s = '0;
        end
    end

    // Next-state bitmap with the free count recomputed exactly from it.
    always_comb begin
        busy_d        = (busy_q | alloc_set_s) & ~(free_clr_s | kill_clr_s);
        free_cnt_d    = count_free(busy_d);
        allocatable_d = (free_cnt_d >= (IQ_ENT_SEL+1)'(2));
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q        <= '0;
            free_cnt_q    <= (IQ_ENT_SEL+1)'(IQ_ENT_NUM);
            allocatable_q <= 1'b1;
        end else begin
            busy_q        <= busy_d;
            free_cnt_q    <= free_cnt_d;
            allocatable_q <= allocatable_d;
        end
    end

    assign free_cnt    = free_cnt_q;
    assign allocatable = allocatable_q;

endmodule

// File: doc/iq_entry_allocator.md
Name: iq_entry_allocator

Overview:
Dispatch-side free-entry manager for the issue queue. It keeps a busy bitmap of IQ entries and offers the two lowest-numbered free entries to dispatch each cycle. It generates the dispatch stall when too few entries are free, and reclaims entries on issue and on misprediction kill. It sits directly upstream of the issue queue and drives its iq_entry_num_1/2 and stall_DP inputs.

Parameters:
IQ_ENT_NUM, 16, number of issue-queue entries; power of two, minimum 4.
IQ_ENT_SEL, 4, entry index width; equals log2(IQ_ENT_NUM).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high; clears all state
invalid1  in  1  dispatch slot 1 carries no instruction
invalid2  in  1  dispatch slot 2 carries no instruction
ext_stall  in  1  downstream stall (ROB/LSQ full); blocks allocation
iq_entry_num_1  out  IQ_ENT_SEL  entry offered to slot 1 (lowest free)
iq_entry_num_2  out  IQ_ENT_SEL  entry offered to slot 2 (second-lowest free)
stall_DP  out  1  dispatch stall; no allocation this cycle when 1
free_1  in  1  issue port 1 releases an entry
free_entry_1  in  IQ_ENT_SEL  entry released by port 1
free_2  in  1  issue port 2 releases an entry
free_entry_2  in  IQ_ENT_SEL  entry released by port 2
prmiss  in  1  misprediction recovery cycle
kill_mask  in  IQ_ENT_NUM  entries squashed by the IQ on prmiss (bit i = entry i)
free_cnt  out  IQ_ENT_SEL+1  registered count of free entries
allocatable  out  1  registered; 1 when free_cnt >= 2

Behaviour:
- State: busy[IQ_ENT_NUM] and free_cnt register. On reset assertion (asynchronous): busy = all 0, free_cnt = IQ_ENT_NUM, allocatable = 1. iq_entry_num_1 = 0, iq_entry_num_2 = 1 and stall_DP = ext_stall then follow combinationally.
- iq_entry_num_1 is the lowest index with busy = 0. iq_entry_num_2 is the next-lowest index with busy = 0 above it. Both are combinational from the registered bitmap only; no same-cycle bypass of frees. Either output is 0 when its entry does not exist.
- Slot 2 always uses iq_entry_num_2, even when invalid1 = 1.
- short = (~invalid1 & free_cnt == 0) | (~invalid2 & free_cnt < 2).
- stall_DP = ext_stall | short | prmiss.
- Allocate when stall_DP = 0:
  - set busy[iq_entry_num_1] if ~invalid1.
  - set busy[iq_entry_num_2] if ~invalid2.
  - When stall_DP = 1, no bit is set (all-or-nothing; no partial allocation).
- Free: on a clock edge with free_k = 1, clear busy[free_entry_k].
  - A free of an entry that is already free is ignored and does not change the count.
  - free_entry_1 == free_entry_2 with both valid counts as one release.
- prmiss cycle:
  - Allocation is blocked via stall_DP.
  - Clear every busy bit set in kill_mask, together with any issue frees in the same cycle.
  - Bits in kill_mask that are already free are ignored.
- Next-state bitmap: busy_next = (busy | alloc_set) & ~(free_clr | kill_clr). Alloc and clear never target the same entry, because only free entries are allocated.
- free_cnt_next = population count of ~busy_next. It must be computed exactly, never by incremental arithmetic. It is registered with the bitmap. allocatable is registered as (free_cnt_next >= 2).
- Invariant: free_cnt equals the popcount of ~busy at every cycle; range 0..IQ_ENT_NUM.
- Full (free_cnt = 0): any valid slot stalls; frees that cycle become allocatable next cycle.
- One free entry: a single valid instruction in slot 1 dispatches; an instruction in slot 2 stalls the pair.
- Reset asserted mid-operation overrides everything, including pending allocation, frees and prmiss.

Test Plan:
- Reset then both slots valid for 8 cycles (IQ_ENT_NUM = 16): allocated pairs are (0,1),(2,3)…(14,15); free_cnt steps 16,14,…,0; stall_DP = 1 on cycle 9.
- Full queue, free_1 = 1 with entry 5: same cycle stall_DP stays 1; next cycle iq_entry_num_1 = 5, free_cnt = 1, allocatable = 0; invalid2 = 1 dispatch succeeds and free_cnt returns to 0.
- Busy = all except entries 3 and 9, both slots valid: entries 3 and 9 allocated; simultaneous free_1 = 3 is rejected as a no-op (3 was free at sample) and 3 becomes busy.
- prmiss with kill_mask = 0x00F0 on a full queue plus free_2 = 0: stall_DP = 1 that cycle; next cycle free_cnt = 5 and iq_entry_num_1/2 = 0/4.
- ext_stall = 1 with 10 free entries: no bitmap change and free_cnt holds 10; deassertion allocates the lowest two free entries.
- Reset asserted asynchronously mid-cycle with half the entries busy: all outputs return immediately to reset values (free_cnt = 16, allocatable = 1).
